// File: rtl/amiga_bus_responder_if.sv
// 68000-style bus signal bundle between an Amiga-side initiator and the responder.
`timescale 1ns/1ps
interface amiga_bus_responder_if;
    logic        nSEL;
    logic        nAS;
    logic        nUDS;
    logic        nLDS;
    logic        RnW;
    logic [1:0]  A;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        DOE;
    logic        nDTACK;

    modport master (
        output nSEL, nAS, nUDS, nLDS, RnW, A, DIN,
        input  DOUT, DOE, nDTACK
    );

    modport slave (
        input  nSEL, nAS, nUDS, nLDS, RnW, A, DIN,
        output DOUT, DOE, nDTACK
    );
endinterface

// File: rtl/amiga_bus_responder.sv
// 68000-style bus target on CLK40: synchronized strobes, four 16-bit byte-lane registers,
// programmable wait states before nDTACK.
`timescale 1ns/1ps
module amiga_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] REG_RESET   = 16'h0000
) (
    input logic                  CLK40,
    input logic                  RESET,
    amiga_bus_responder_if.slave bus
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                        r_state, w_state_next;
    logic [SYNC_STAGES-1:0][4:0]   r_sync;
    logic [4:0]                    w_raw, w_synced;
    logic                          w_as_n, w_sel_n, w_uds_n, w_lds_n, w_rnw;
    logic                          w_start;
    logic [3:0]                    r_cnt;
    logic [1:0]                    r_addr, r_lanes;
    logic                          r_rnw;
    logic [15:0]                   r_regs [4];
    logic                          r_dtack_n, r_doe;
    logic [15:0]                   r_dout;
    logic                          w_dtack_n_next, w_doe_next, w_load, w_commit;

    assign w_raw    = {bus.nAS, bus.nSEL, bus.nUDS, bus.nLDS, bus.RnW};
    assign w_synced = r_sync[SYNC_STAGES-1];
    assign {w_as_n, w_sel_n, w_uds_n, w_lds_n, w_rnw} = w_synced;
    assign w_start  = ~w_as_n & ~w_sel_n & (~w_uds_n | ~w_lds_n);

    // Element 0 takes the raw pins; the oldest sample sits in the top element.
    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
        end
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_start) w_state_next = StWait;
            StWait: begin
                if (w_as_n) begin
                    w_state_next = StIdle;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = StAck;
                end
            end
            StAck:  if (w_as_n) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Abort (nAS negated) wins over an expiring counter in WAIT.
    always_comb begin
        w_load         = 1'b0;
        w_commit       = 1'b0;
        w_dtack_n_next = r_dtack_n;
        w_doe_next     = r_doe;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_load     = 1'b1;
                    w_doe_next = w_rnw;
                end
            end
            StWait: begin
                if (w_as_n) begin
                    w_doe_next = 1'b0;
                end else if (r_cnt == 4'd0) begin
                    w_dtack_n_next = 1'b0;
                    w_commit       = ~r_rnw;
                end
            end
            StAck: begin
                if (w_as_n) begin
                    w_dtack_n_next = 1'b1;
                    w_doe_next     = 1'b0;
                end
            end
            default: begin
                w_dtack_n_next = 1'b1;
                w_doe_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            r_cnt     <= 4'd0;
            r_addr    <= 2'd0;
            r_lanes   <= 2'd0;
            r_rnw     <= 1'b1;
            r_dtack_n <= 1'b1;
            r_doe     <= 1'b0;
            r_dout    <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= REG_RESET;
            end
        end else begin
            r_dtack_n <= w_dtack_n_next;
            r_doe     <= w_doe_next;
            if (w_load) begin
                r_addr  <= bus.A;
                r_rnw   <= w_rnw;
                r_lanes <= {~w_uds_n, ~w_lds_n};
                r_cnt   <= WaitLoad;
                if (w_rnw) begin
                    r_dout <= r_regs[bus.A];
                end
            end else if (r_state == StWait && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // DIN is only trusted on the acknowledging edge.
            if (w_commit) begin
                if (r_lanes[1]) r_regs[r_addr][15:8] <= bus.DIN[15:8];
                if (r_lanes[0]) r_regs[r_addr][7:0]  <= bus.DIN[7:0];
            end
        end
    end

    assign bus.nDTACK = r_dtack_n;
    assign bus.DOE    = r_doe;
    assign bus.DOUT   = r_dout;

endmodule

// File: tb/tb_amiga_bus_responder.sv
// Bench for amiga_bus_responder: two instances (2 and 8 wait states) share one stimulus,
// checked every cycle against an edge-counting transaction model plus literal expectations.
`timescale 1ns/1ps
module tb_amiga_bus_responder;
    localparam int SYNC = 2;
    localparam int W0   = 2;
    localparam int W1   = 8;

    logic        CLK40 = 1'b0;
    logic        RESET = 1'b1;
    logic        nSEL  = 1'b1;
    logic        nAS   = 1'b1;
    logic        nUDS  = 1'b1;
    logic        nLDS  = 1'b1;
    logic        RnW   = 1'b1;
    logic [1:0]  A     = 2'd0;
    logic [15:0] DIN   = 16'h0000;

    always #12.5 CLK40 = ~CLK40;

    amiga_bus_responder_if bus0 ();
    amiga_bus_responder_if bus1 ();

    assign bus0.nSEL = nSEL;
    assign bus0.nAS  = nAS;
    assign bus0.nUDS = nUDS;
    assign bus0.nLDS = nLDS;
    assign bus0.RnW  = RnW;
    assign bus0.A    = A;
    assign bus0.DIN  = DIN;
    assign bus1.nSEL = nSEL;
    assign bus1.nAS  = nAS;
    assign bus1.nUDS = nUDS;
    assign bus1.nLDS = nLDS;
    assign bus1.RnW  = RnW;
    assign bus1.A    = A;
    assign bus1.DIN  = DIN;

    amiga_bus_responder #(.WAIT_CYCLES(W0), .SYNC_STAGES(SYNC), .REG_RESET(16'h0000)) dut0 (
        .CLK40 (CLK40),
        .RESET (RESET),
        .bus   (bus0)
    );

    amiga_bus_responder #(.WAIT_CYCLES(W1), .SYNC_STAGES(SYNC), .REG_RESET(16'h0000)) dut1 (
        .CLK40 (CLK40),
        .RESET (RESET),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int edge_cnt = 0;

    always @(posedge CLK40) edge_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: decisions made on edge numbers relative to the recognised start.
    logic [4:0]  m_q [$];
    logic [4:0]  m_s;
    int          m_edge = 0;
    int          m_wk;
    bit          m_busy  [2];
    bit          m_acked [2];
    bit          m_rnw   [2];
    int          m_start [2];
    logic [1:0]  m_addr  [2];
    logic [1:0]  m_lanes [2];
    logic [15:0] m_regs  [2][4];
    logic        exp_dtack_n [2] = '{1'b1, 1'b1};
    logic        exp_doe     [2] = '{1'b0, 1'b0};
    logic [15:0] exp_dout    [2] = '{16'h0000, 16'h0000};

    always @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            m_q.delete();
            repeat (SYNC) m_q.push_back(5'b11111);
            for (int k = 0; k < 2; k++) begin
                m_busy[k]      = 1'b0;
                m_acked[k]     = 1'b0;
                exp_dtack_n[k] = 1'b1;
                exp_doe[k]     = 1'b0;
                exp_dout[k]    = 16'h0000;
                for (int i = 0; i < 4; i++) m_regs[k][i] = 16'h0000;
            end
        end else begin
            m_edge++;
            m_s = m_q.pop_front();
            m_q.push_back({nAS, nSEL, nUDS, nLDS, RnW});
            for (int k = 0; k < 2; k++) begin
                m_wk = (k == 0) ? W0 : W1;
                if (!m_busy[k]) begin
                    if (!m_s[4] && !m_s[3] && (!m_s[2] || !m_s[1])) begin
                        m_busy[k]  = 1'b1;
                        m_acked[k] = 1'b0;
                        m_start[k] = m_edge;
                        m_addr[k]  = A;
                        m_rnw[k]   = m_s[0];
                        m_lanes[k] = {!m_s[2], !m_s[1]};
                        if (m_s[0]) begin
                            exp_doe[k]  = 1'b1;
                            exp_dout[k] = m_regs[k][A];
                        end
                    end
                end else if (!m_acked[k]) begin
                    if (m_s[4]) begin
                        m_busy[k]  = 1'b0;
                        exp_doe[k] = 1'b0;
                    end else if (m_edge == m_start[k] + m_wk + 1) begin
                        m_acked[k]     = 1'b1;
                        exp_dtack_n[k] = 1'b0;
                        if (!m_rnw[k]) begin
                            if (m_lanes[k][1]) m_regs[k][m_addr[k]][15:8] = DIN[15:8];
                            if (m_lanes[k][0]) m_regs[k][m_addr[k]][7:0]  = DIN[7:0];
                        end
                    end
                end else if (m_s[4]) begin
                    m_busy[k]      = 1'b0;
                    m_acked[k]     = 1'b0;
                    exp_dtack_n[k] = 1'b1;
                    exp_doe[k]     = 1'b0;
                end
            end
        end
    end

    always @(negedge CLK40) begin
        check("dtack0", 32'(bus0.nDTACK), 32'(exp_dtack_n[0]));
        check("doe0", 32'(bus0.DOE), 32'(exp_doe[0]));
        if (exp_doe[0]) check("dout0", 32'(bus0.DOUT), 32'(exp_dout[0]));
        check("dtack1", 32'(bus1.nDTACK), 32'(exp_dtack_n[1]));
        check("doe1", 32'(bus1.DOE), 32'(exp_doe[1]));
        if (exp_doe[1]) check("dout1", 32'(bus1.DOUT), 32'(exp_dout[1]));
    end

    task automatic wait_ack(input int c, output int ack0, output int ack1,
                            output logic [15:0] rd0, output logic [15:0] rd1);
        ack0 = -1;
        ack1 = -1;
        rd0  = 16'hxxxx;
        rd1  = 16'hxxxx;
        for (int i = 0; i < 40 && (ack0 < 0 || ack1 < 0); i++) begin
            @(negedge CLK40);
            if (ack0 < 0 && bus0.nDTACK == 1'b0) begin
                ack0 = edge_cnt - c;
                rd0  = bus0.DOUT;
            end
            if (ack1 < 0 && bus1.nDTACK == 1'b0) begin
                ack1 = edge_cnt - c;
                rd1  = bus1.DOUT;
            end
        end
        check("ack_edge0", ack0, 32'd6);
        check("ack_edge1", ack1, 32'd12);
    endtask

    task automatic bus_cycle(input bit rnw, input logic [1:0] a, input logic [15:0] din,
                             input bit uds, input bit lds, input int hold,
                             output logic [15:0] rd0, output logic [15:0] rd1);
        int c, ack0, ack1, rel0;
        @(negedge CLK40);
        RnW  = rnw;
        A    = a;
        DIN  = din;
        nSEL = 1'b0;
        nUDS = ~uds;
        nLDS = ~lds;
        nAS  = 1'b0;
        c    = edge_cnt;
        wait_ack(c, ack0, ack1, rd0, rd1);
        if (hold > 0) begin
            repeat (hold) @(negedge CLK40);
            check("dtack_held", {30'd0, bus0.nDTACK, bus1.nDTACK}, 32'd0);
        end
        nAS  = 1'b1;
        nUDS = 1'b1;
        nLDS = 1'b1;
        nSEL = 1'b1;
        c    = edge_cnt;
        rel0 = -1;
        for (int i = 0; i < 20 && rel0 < 0; i++) begin
            @(negedge CLK40);
            if (bus0.nDTACK && !bus0.DOE) rel0 = edge_cnt - c;
        end
        check("release_edge0", rel0, 32'd3);
        repeat (3) @(negedge CLK40);
    endtask

    task automatic quiet_window(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge CLK40);
            if (!bus0.nDTACK || bus0.DOE || !bus1.nDTACK || bus1.DOE) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd0, rd1;
        int c, ack0, ack1;
        bit seen_ack1, seen_doe1;

        repeat (3) @(negedge CLK40);
        check("rst_dtack", {30'd0, bus0.nDTACK, bus1.nDTACK}, 32'd3);
        check("rst_doe", {30'd0, bus0.DOE, bus1.DOE}, 32'd0);
        check("rst_dout", {bus0.DOUT, bus1.DOUT}, 32'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK40);

        // Word write then read.
        bus_cycle(1'b0, 2'd1, 16'hA5C3, 1'b1, 1'b1, 0, rd0, rd1);
        bus_cycle(1'b1, 2'd1, 16'h0000, 1'b1, 1'b1, 0, rd0, rd1);
        check("word_rd0", 32'(rd0), 32'h0000A5C3);
        check("word_rd1", 32'(rd1), 32'h0000A5C3);

        // Byte lanes on reg2.
        bus_cycle(1'b0, 2'd2, 16'h1234, 1'b0, 1'b1, 0, rd0, rd1);
        bus_cycle(1'b0, 2'd2, 16'hAB00, 1'b1, 1'b0, 0, rd0, rd1);
        bus_cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b1, 0, rd0, rd1);
        check("lane_rd0", 32'(rd0), 32'h0000AB34);
        check("lane_rd1", 32'(rd1), 32'h0000AB34);

        // Aborted write on the 8-wait instance: nAS rises before its counter expires.
        @(negedge CLK40);
        RnW  = 1'b0;
        A    = 2'd3;
        DIN  = 16'hFFFF;
        nSEL = 1'b0;
        nUDS = 1'b0;
        nLDS = 1'b0;
        nAS  = 1'b0;
        seen_ack1 = 1'b0;
        seen_doe1 = 1'b0;
        repeat (8) begin
            @(negedge CLK40);
            if (!bus1.nDTACK) seen_ack1 = 1'b1;
            if (bus1.DOE) seen_doe1 = 1'b1;
        end
        nAS  = 1'b1;
        nUDS = 1'b1;
        nLDS = 1'b1;
        nSEL = 1'b1;
        repeat (10) begin
            @(negedge CLK40);
            if (!bus1.nDTACK) seen_ack1 = 1'b1;
            if (bus1.DOE) seen_doe1 = 1'b1;
        end
        check("abort_no_ack1", 32'(seen_ack1), 32'd0);
        check("abort_no_doe1", 32'(seen_doe1), 32'd0);
        bus_cycle(1'b1, 2'd3, 16'h0000, 1'b1, 1'b1, 0, rd0, rd1);
        check("abort_rd0", 32'(rd0), 32'h0000FFFF);
        check("abort_rd1", 32'(rd1), 32'h00000000);

        // Not selected, then selected without strobes.
        @(negedge CLK40);
        RnW  = 1'b1;
        A    = 2'd1;
        nSEL = 1'b1;
        nUDS = 1'b0;
        nLDS = 1'b0;
        nAS  = 1'b0;
        quiet_window("nsel_quiet", 12);
        nAS  = 1'b1;
        nUDS = 1'b1;
        nLDS = 1'b1;
        repeat (4) @(negedge CLK40);
        nSEL = 1'b0;
        nAS  = 1'b0;
        quiet_window("nostrobe_quiet", 12);
        nAS  = 1'b1;
        nSEL = 1'b1;
        repeat (4) @(negedge CLK40);

        // Long hold after acknowledge, then a normal follow-up cycle.
        bus_cycle(1'b1, 2'd1, 16'h0000, 1'b1, 1'b1, 20, rd0, rd1);
        check("hold_rd0", 32'(rd0), 32'h0000A5C3);
        bus_cycle(1'b1, 2'd2, 16'h0000, 1'b0, 1'b1, 0, rd0, rd1);
        check("next_rd0", 32'(rd0), 32'h0000AB34);

        // Reset while acknowledging a read.
        @(negedge CLK40);
        RnW  = 1'b1;
        A    = 2'd1;
        nSEL = 1'b0;
        nUDS = 1'b0;
        nLDS = 1'b0;
        nAS  = 1'b0;
        c    = edge_cnt;
        wait_ack(c, ack0, ack1, rd0, rd1);
        #5;
        RESET = 1'b1;
        #1;
        check("midrst_dtack", {30'd0, bus0.nDTACK, bus1.nDTACK}, 32'd3);
        check("midrst_doe", {30'd0, bus0.DOE, bus1.DOE}, 32'd0);
        nAS  = 1'b1;
        nUDS = 1'b1;
        nLDS = 1'b1;
        nSEL = 1'b1;
        repeat (3) @(negedge CLK40);
        RESET = 1'b0;
        repeat (3) @(negedge CLK40);
        for (int r = 0; r < 4; r++) begin
            bus_cycle(1'b1, 2'(r), 16'h0000, 1'b1, 1'b1, 0, rd0, rd1);
            check($sformatf("postrst_rd%0d", r), {rd0, rd1}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
